traffic_injection_ctrl: RTL and testbench

Run controller for the TCDM traffic generator path. It sequences a measurement run through warm-up, measurement and drain phases, and throttles the generator's request stream with a fractional-rate token bucket and an outstanding-read limit. It also counts issued and retired transactions inside the measurement window. It sits between a core's request source and the address demux that feeds the TCDM ports.

---
 rtl/traffic_injection_ctrl_if.sv | 25 ++
 rtl/traffic_injection_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_traffic_injection_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_injection_ctrl_if.sv
// Handshake bundle between the traffic generator, the injection controller and the TCDM demux.
// The master view belongs to the controller; the slave view is the surrounding generator/demux.
interface traffic_injection_ctrl_if;
    logic gen_valid;
    logic gen_ready;
    logic req_valid;
    logic req_ready;
    logic resp_valid;

    modport master (
        input  gen_valid,
        output gen_ready,
        output req_valid,
        input  req_ready,
        input  resp_valid
    );

    modport slave (
        output gen_valid,
        input  gen_ready,
        input  req_valid,
        output req_ready,
        output resp_valid
    );
endinterface

// File: rtl/traffic_injection_ctrl.sv
// Run controller for the TCDM traffic generator: warm-up/measure/drain sequencing, token-bucket
// rate throttling, outstanding-read limiting and in-window issue/retire statistics.
module traffic_injection_ctrl #(
    parameter int unsigned MaxOutstanding = 1024,
    parameter int unsigned RateWidth      = 8,
    parameter int unsigned CntWidth       = 32,
    parameter int unsigned OstWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [CntWidth-1:0]     warmup_cycles_i,
    input  logic [CntWidth-1:0]     measure_cycles_i,
    input  logic [RateWidth:0]      rate_i,
    traffic_injection_ctrl_if.master hs,
    output logic                    busy_o,
    output logic                    measuring_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [OstWidth-1:0]     outstanding_o,
    output logic [CntWidth-1:0]     issued_o,
    output logic [CntWidth-1:0]     retired_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
    localparam logic [OstWidth-1:0] OstOne = OstWidth'(1);
    localparam logic [OstWidth-1:0] OstMax = OstWidth'(MaxOutstanding);

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        if (v == {CntWidth{1'b1}}) begin
            return v;
        end else begin
            return v + CntOne;
        end
    endfunction

    state_e                 state_r, state_d;
    logic [CntWidth-1:0]    cnt_r, cnt_d;
    logic [CntWidth-1:0]    measure_r, measure_d;
    logic [RateWidth:0]     rate_r, rate_d;
    logic [RateWidth-1:0]   acc_r, acc_d;
    logic                   token_r, token_d;
    logic [OstWidth-1:0]    ost_r, ost_d;
    logic [CntWidth-1:0]    issued_r, issued_d;
    logic [CntWidth-1:0]    retired_r, retired_d;
    logic                   error_r, error_d;
    logic                   busy_r, measuring_r, done_r;

    logic                   active_s;
    logic                   allow_s;
    logic                   fire_s;
    logic [RateWidth:0]     acc_sum_s;

    assign active_s  = (state_r == ST_WARMUP) || (state_r == ST_MEASURE);
    assign allow_s   = active_s && token_r && (ost_r < OstMax);
    assign fire_s    = hs.gen_valid && hs.req_ready && allow_s;
    assign acc_sum_s = {1'b0, acc_r} + rate_r;

    assign hs.req_valid = hs.gen_valid & allow_s;
    assign hs.gen_ready = hs.req_ready & allow_s;

    // Next-state, phase counter, token bucket, outstanding tracking and statistics
    always_comb begin
        state_d   = state_r;
        cnt_d     = cnt_r;
        measure_d = measure_r;
        rate_d    = rate_r;
        acc_d     = acc_r;
        token_d   = token_r;
        ost_d     = ost_r;
        issued_d  = issued_r;
        retired_d = retired_r;
        error_d   = error_r;

        // A response with nothing in flight is a protocol error; the count stays at zero.
        if (fire_s && !hs.resp_valid) begin
            ost_d = ost_r + OstOne;
        end else if (!fire_s && hs.resp_valid && (ost_r != '0)) begin
            ost_d = ost_r - OstOne;
        end else begin
            ost_d = ost_r;
        end

        if (hs.resp_valid && (ost_r == '0)) begin
            error_d = 1'b1;
        end else begin
            error_d = error_r;
        end

        if (active_s) begin
            acc_d   = acc_sum_s[RateWidth-1:0];
            token_d = acc_sum_s[RateWidth] | (token_r & ~fire_s);
        end else begin
            acc_d   = acc_r;
            token_d = token_r;
        end

        if (state_r == ST_MEASURE) begin
            issued_d  = fire_s ? sat_inc(issued_r) : issued_r;
            retired_d = hs.resp_valid ? sat_inc(retired_r) : retired_r;
        end else begin
            issued_d  = issued_r;
            retired_d = retired_r;
        end

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    measure_d = measure_cycles_i;
                    rate_d    = rate_i;
                    acc_d     = '0;
                    token_d   = 1'b1;
                    issued_d  = '0;
                    retired_d = '0;
                    error_d   = 1'b0;
                    if (warmup_cycles_i != '0) begin
                        state_d = ST_WARMUP;
                        cnt_d   = warmup_cycles_i;
                    end else if (measure_cycles_i != '0) begin
                        state_d = ST_MEASURE;
                        cnt_d   = measure_cycles_i;
                    end else begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end
                end else begin
                    state_d = state_r;
                end
            end
            ST_WARMUP: begin
                if (cnt_r == CntOne) begin
                    if (measure_r != '0) begin
                        state_d = ST_MEASURE;
                        cnt_d   = measure_r;
                    end else begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_r - CntOne;
                end
            end
            ST_MEASURE: begin
                if (cnt_r == CntOne) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_r - CntOne;
                end
            end
            ST_DRAIN: begin
                if (ost_r == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, datapath and status registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            measure_r   <= '0;
            rate_r      <= '0;
            acc_r       <= '0;
            token_r     <= 1'b0;
            ost_r       <= '0;
            issued_r    <= '0;
            retired_r   <= '0;
            error_r     <= 1'b0;
            busy_r      <= 1'b0;
            measuring_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_d;
            cnt_r       <= cnt_d;
            measure_r   <= measure_d;
            rate_r      <= rate_d;
            acc_r       <= acc_d;
            token_r     <= token_d;
            ost_r       <= ost_d;
            issued_r    <= issued_d;
            retired_r   <= retired_d;
            error_r     <= error_d;
            busy_r      <= (state_d == ST_WARMUP) || (state_d == ST_MEASURE) ||
                           (state_d == ST_DRAIN);
            measuring_r <= (state_d == ST_MEASURE);
            done_r      <= (state_d == ST_DONE);
        end
    end

    assign busy_o        = busy_r;
    assign measuring_o   = measuring_r;
    assign done_o        = done_r;
    assign error_o       = error_r;
    assign outstanding_o = ost_r;
    assign issued_o      = issued_r;
    assign retired_o     = retired_r;

endmodule

// File: tb/tb_traffic_injection_ctrl.sv
// Directed bench for traffic_injection_ctrl with hand-computed expectations (MaxOutstanding = 4).
module tb_traffic_injection_ctrl;

    localparam int unsigned MaxOst = 4;
    localparam int unsigned RateW  = 8;
    localparam int unsigned CntW   = 32;
    localparam int unsigned OstW   = $clog2(MaxOst + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CntW-1:0]  warm;
    logic [CntW-1:0]  meas;
    logic [RateW:0]   rate;
    logic             busy;
    logic             measuring;
    logic             done;
    logic             error;
    logic [OstW-1:0]  ost;
    logic [CntW-1:0]  issued;
    logic [CntW-1:0]  retired;

    int               n_cmp = 0;
    int               n_err = 0;
    int               fires;
    logic [15:0]      mask;

    traffic_injection_ctrl_if hs_if ();

    traffic_injection_ctrl #(
        .MaxOutstanding (MaxOst),
        .RateWidth      (RateW),
        .CntWidth       (CntW)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .warmup_cycles_i  (warm),
        .measure_cycles_i (meas),
        .rate_i           (rate),
        .hs               (hs_if),
        .busy_o           (busy),
        .measuring_o      (measuring),
        .done_o           (done),
        .error_o          (error),
        .outstanding_o    (ost),
        .issued_o         (issued),
        .retired_o        (retired)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] w, input logic [31:0] m, input logic [8:0] r);
        warm  = w;
        meas  = m;
        rate  = r;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        warm = '0;
        meas = '0;
        rate = '0;
        hs_if.gen_valid  = 1'b1;
        hs_if.req_ready  = 1'b1;
        hs_if.resp_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_error", error, 0);
        check_eq("rst_ost", ost, 0);
        check_eq("rst_issued", issued, 0);
        check_eq("rst_req_valid", hs_if.req_valid, 0);
        check_eq("rst_gen_ready", hs_if.gen_ready, 0);
        tick();

        // Full rate, responses two cycles after issue
        pulse_start(0, 10, 9'd256);
        fires = 0;
        for (int k = 1; k <= 14; k++) begin
            hs_if.resp_valid = (k >= 3) && (k <= 12);
            @(negedge clk);
            fires += int'(hs_if.req_valid && hs_if.req_ready);
            if (k == 12) begin
                check_eq("t1_drain_busy", busy, 1);
                check_eq("t1_drain_not_done", done, 0);
            end
            tick();
        end
        hs_if.resp_valid = 1'b0;
        @(negedge clk);
        check_eq("t1_fires", fires, 10);
        check_eq("t1_issued", issued, 10);
        check_eq("t1_retired", retired, 8);
        check_eq("t1_done", done, 1);
        check_eq("t1_ost", ost, 0);
        check_eq("t1_busy", busy, 0);
        tick();

        // Half rate: fires on odd measurement cycles
        pulse_start(0, 10, 9'd128);
        mask = '0;
        for (int k = 1; k <= 12; k++) begin
            hs_if.resp_valid = ((k % 2) == 0) && (k <= 10);
            @(negedge clk);
            if (hs_if.req_valid && hs_if.req_ready) begin
                mask[k] = 1'b1;
            end
            tick();
        end
        hs_if.resp_valid = 1'b0;
        @(negedge clk);
        check_eq("t2_fire_mask", {16'd0, mask}, 32'h0000_02AA);
        check_eq("t2_issued", issued, 5);
        check_eq("t2_retired", retired, 5);
        check_eq("t2_done", done, 1);
        tick();

        // Outstanding limit, then reset mid-measurement with 3 in flight
        pulse_start(0, 20, 9'd256);
        fires = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            fires += int'(hs_if.req_valid && hs_if.req_ready);
            tick();
        end
        check_eq("t3_fires_to_limit", fires, 4);
        fires = 0;
        for (int k = 9; k <= 14; k++) begin
            hs_if.resp_valid = (k == 9);
            @(negedge clk);
            if (k == 9) begin
                check_eq("t3_stall_req_valid", hs_if.req_valid, 0);
                check_eq("t3_stall_ost", ost, 4);
            end
            fires += int'(hs_if.req_valid && hs_if.req_ready);
            tick();
        end
        check_eq("t3_one_more_fire", fires, 1);
        hs_if.gen_valid  = 1'b0;
        hs_if.resp_valid = 1'b1;
        tick();
        hs_if.gen_valid  = 1'b1;
        hs_if.resp_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_eq("t3_ost_before_rst", ost, 3);
        check_eq("t3_issued_before_rst", issued, 5);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_measuring", measuring, 0);
        check_eq("t6_rst_ost", ost, 0);
        check_eq("t6_rst_issued", issued, 0);
        check_eq("t6_rst_retired", retired, 0);
        check_eq("t6_rst_req_valid", hs_if.req_valid, 0);
        tick();

        // Simultaneous fire/response, response at zero, ignored start
        pulse_start(0, 20, 9'd256);
        tick();
        tick();
        hs_if.resp_valid = 1'b1;
        @(negedge clk);
        check_eq("t4_fire_with_resp", hs_if.req_valid, 1);
        tick();
        hs_if.gen_valid = 1'b0;
        @(negedge clk);
        check_eq("t4_ost_hold", ost, 2);
        tick();
        tick();
        @(negedge clk);
        check_eq("t4_ost_zero", ost, 0);
        check_eq("t4_no_error_yet", error, 0);
        tick();
        hs_if.resp_valid = 1'b0;
        @(negedge clk);
        check_eq("t4_error_set", error, 1);
        check_eq("t4_ost_stays_zero", ost, 0);
        tick();
        warm  = 5;
        meas  = 5;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check_eq("t5_start_ignored", measuring, 1);
        check_eq("t4_error_sticky", error, 1);
        check_eq("t4_issued", issued, 3);
        for (int k = 0; k < 13; k++) begin
            tick();
        end
        @(negedge clk);
        check_eq("t4_done", done, 1);
        tick();

        // Warm-up 5, measure 5: measurement window is cycles 6..10
        hs_if.gen_valid = 1'b1;
        pulse_start(5, 5, 9'd256);
        mask = '0;
        for (int k = 1; k <= 14; k++) begin
            hs_if.resp_valid = (k >= 2) && (k <= 11);
            @(negedge clk);
            if (measuring) begin
                mask[k] = 1'b1;
            end
            if (k == 1) begin
                check_eq("t5_busy_after_start", busy, 1);
                check_eq("t5_error_cleared", error, 0);
            end
            tick();
        end
        hs_if.resp_valid = 1'b0;
        @(negedge clk);
        check_eq("t5_measure_mask", {16'd0, mask}, 32'h0000_07C0);
        check_eq("t5_issued", issued, 5);
        check_eq("t5_retired", retired, 5);
        check_eq("t5_done", done, 1);
        check_eq("t5_ost", ost, 0);
        tick();

        // Zero-length run goes straight through a one-cycle drain
        pulse_start(0, 0, 9'd256);
        @(negedge clk);
        check_eq("t7_drain_busy", busy, 1);
        check_eq("t7_drain_measuring", measuring, 0);
        check_eq("t7_drain_req_valid", hs_if.req_valid, 0);
        tick();
        @(negedge clk);
        check_eq("t7_done", done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
